// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB transmit path arbiter.
// Holds the arbiter FSM states, the path-select encoding and the round-robin pick.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_SENT = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  typedef enum logic {
    SEL_NRZI = 1'b0,
    SEL_PH   = 1'b1
  } path_sel_e;

  localparam int unsigned DEFAULT_GAP_CYCLES = 2;
  localparam int unsigned DEFAULT_TIMEOUT    = 1000;

  // A lone requester always wins; on a tie the path not served last goes next.
  function automatic path_sel_e pick_winner(input logic nrziReq,
                                            input logic phReq,
                                            input path_sel_e lastServed);
    path_sel_e winner;
    if (nrziReq && phReq) begin
      winner = (lastServed == SEL_PH) ? SEL_NRZI : SEL_PH;
    end else if (phReq) begin
      winner = SEL_PH;
    end else begin
      winner = SEL_NRZI;
    end
    return winner;
  endfunction

endpackage

// File: rtl/dpdm_tx_arbiter_if.sv
// Bundle of request, serial data and grant signals between the two transmit
// sources, the DPDM encoder and the arbiter that sits between them.
interface dpdm_tx_arbiter_if;

  logic nrzi_req;
  logic nrzi_in_bit;
  logic nrzi_sending;
  logic ph_req;
  logic ph_in_bit;
  logic ph_sending;
  logic sent;

  logic nrzi_grant;
  logic ph_grant;
  logic enc_in_bit;
  logic enc_sending;
  logic busy;
  logic timeout_err;

  modport slave (
    input  nrzi_req, nrzi_in_bit, nrzi_sending,
    input  ph_req, ph_in_bit, ph_sending,
    input  sent,
    output nrzi_grant, ph_grant,
    output enc_in_bit, enc_sending,
    output busy, timeout_err
  );

  modport master (
    output nrzi_req, nrzi_in_bit, nrzi_sending,
    output ph_req, ph_in_bit, ph_sending,
    output sent,
    input  nrzi_grant, ph_grant,
    input  enc_in_bit, enc_sending,
    input  busy, timeout_err
  );

endinterface

// File: rtl/down_counter.sv
// Loadable saturating down counter with a zero flag; load wins over decrement.
// Used by the arbiter for both the inter-packet gap and the grant timeout.
module down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dpdm_tx_arbiter.sv
// Round-robin arbiter sharing one DPDM encoder between the NRZI and protocol
// handler paths, with a minimum idle gap between packets and a grant timeout.
module dpdm_tx_arbiter
  import usb_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  dpdm_tx_arbiter_if.slave bus
);

  localparam logic [3:0]  GapLoad     = 4'(GAP_CYCLES - 1);
  localparam logic [15:0] TimeoutLoad = 16'(TIMEOUT - 1);

  arb_state_e state_q, state_d;
  logic       nrziGrant_q, nrziGrant_d;
  logic       phGrant_q, phGrant_d;
  path_sel_e  lastServed_q, lastServed_d;
  logic       seenSending_q, seenSending_d;
  logic       timeoutErr_q, timeoutErr_d;

  logic       gapLoad, gapDec, gapZero;
  logic       toLoad, toDec, toZero;
  logic       grantedReq, grantedSending;
  path_sel_e  winner;
  path_sel_e  curPath;

  // Counters load one less than the cycle count so "zero" marks the last cycle.
  down_counter #(.WIDTH(4)) gapCounter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (gapLoad),
    .load_val_i (GapLoad),
    .dec_i      (gapDec),
    .zero_o     (gapZero)
  );

  down_counter #(.WIDTH(16)) timeoutCounter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (toLoad),
    .load_val_i (TimeoutLoad),
    .dec_i      (toDec),
    .zero_o     (toZero)
  );

  assign grantedReq     = (nrziGrant_q & bus.nrzi_req)     | (phGrant_q & bus.ph_req);
  assign grantedSending = (nrziGrant_q & bus.nrzi_sending) | (phGrant_q & bus.ph_sending);
  assign curPath        = phGrant_q ? SEL_PH : SEL_NRZI;
  assign winner         = pick_winner(bus.nrzi_req, bus.ph_req, lastServed_q);

  always_comb begin
    state_d       = state_q;
    nrziGrant_d   = nrziGrant_q;
    phGrant_d     = phGrant_q;
    lastServed_d  = lastServed_q;
    seenSending_d = seenSending_q;
    timeoutErr_d  = 1'b0;
    gapLoad       = 1'b0;
    gapDec        = 1'b0;
    toLoad        = 1'b0;
    toDec         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.nrzi_req || bus.ph_req) begin
          state_d       = GRANT;
          nrziGrant_d   = (winner == SEL_NRZI);
          phGrant_d     = (winner == SEL_PH);
          seenSending_d = 1'b0;
          toLoad        = 1'b1;
        end
      end

      GRANT: begin
        if (grantedSending) begin
          seenSending_d = 1'b1;
        end
        // A request withdrawn before any data is a cancel, not a packet.
        if (!seenSending_q && !grantedSending && !grantedReq) begin
          state_d     = IDLE;
          nrziGrant_d = 1'b0;
          phGrant_d   = 1'b0;
        end else if (toZero) begin
          state_d      = GAP;
          nrziGrant_d  = 1'b0;
          phGrant_d    = 1'b0;
          timeoutErr_d = 1'b1;
          gapLoad      = 1'b1;
        end else begin
          toDec = 1'b1;
          if (seenSending_q && !grantedSending) begin
            state_d = WAIT_SENT;
          end
        end
      end

      WAIT_SENT: begin
        if (bus.sent) begin
          state_d      = GAP;
          nrziGrant_d  = 1'b0;
          phGrant_d    = 1'b0;
          lastServed_d = curPath;
          gapLoad      = 1'b1;
        end else if (toZero) begin
          state_d      = GAP;
          nrziGrant_d  = 1'b0;
          phGrant_d    = 1'b0;
          timeoutErr_d = 1'b1;
          gapLoad      = 1'b1;
        end else begin
          toDec = 1'b1;
        end
      end

      GAP: begin
        if (gapZero) begin
          state_d = IDLE;
        end else begin
          gapDec = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        nrziGrant_d = 1'b0;
        phGrant_d   = 1'b0;
      end
    endcase
  end

  // Reset leaves PH as last served so NRZI takes the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      nrziGrant_q   <= 1'b0;
      phGrant_q     <= 1'b0;
      lastServed_q  <= SEL_PH;
      seenSending_q <= 1'b0;
      timeoutErr_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      nrziGrant_q   <= nrziGrant_d;
      phGrant_q     <= phGrant_d;
      lastServed_q  <= lastServed_d;
      seenSending_q <= seenSending_d;
      timeoutErr_q  <= timeoutErr_d;
    end
  end

  always_comb begin
    bus.enc_in_bit  = 1'b0;
    bus.enc_sending = 1'b0;
    if (nrziGrant_q) begin
      bus.enc_in_bit  = bus.nrzi_in_bit;
      bus.enc_sending = bus.nrzi_sending;
    end else if (phGrant_q) begin
      bus.enc_in_bit  = bus.ph_in_bit;
      bus.enc_sending = bus.ph_sending;
    end
  end

  assign bus.nrzi_grant  = nrziGrant_q;
  assign bus.ph_grant    = phGrant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_dpdm_tx_arbiter.sv
// Directed bench for dpdm_tx_arbiter: serial bits are queued as they are driven
// and matched against the encoder-side outputs as they appear.
module tb_dpdm_tx_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  logic sbQ[$];

  dpdm_tx_arbiter_if bus ();

  dpdm_tx_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clock);
    #1;
  endtask

  // Drive nBits serial bits on one path, queueing each as the expected encoder bit.
  task automatic applyStimulus(input bit toNrzi, input logic [7:0] data,
                               input int nBits, input bit phNoise);
    for (int i = 0; i < nBits; i++) begin
      if (toNrzi) begin
        bus.nrzi_sending = 1'b1;
        bus.nrzi_in_bit  = data[i];
      end else begin
        bus.ph_sending = 1'b1;
        bus.ph_in_bit  = data[i];
      end
      if (phNoise) begin
        bus.ph_sending = ((i % 2) == 0);
        bus.ph_in_bit  = ~data[i];
      end
      sbQ.push_back(data[i]);
      nextCycle();
    end
    bus.nrzi_sending = 1'b0;
    bus.nrzi_in_bit  = 1'b0;
    bus.ph_sending   = 1'b0;
    bus.ph_in_bit    = 1'b0;
  endtask

  task automatic checkGrants(input string tag, input logic expNrzi, input logic expPh);
    checkOutput({tag, "_nrzi_grant"}, 32'(bus.nrzi_grant), 32'(expNrzi));
    checkOutput({tag, "_ph_grant"}, 32'(bus.ph_grant), 32'(expPh));
  endtask

  task automatic waitGrant(input string tag, input bit expNrzi, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      nextCycle();
      if (bus.nrzi_grant || bus.ph_grant) break;
    end
    checkGrants(tag, expNrzi, !expNrzi);
  endtask

  task automatic doReset();
    reset_n          = 1'b0;
    bus.nrzi_req     = 1'b0;
    bus.nrzi_in_bit  = 1'b0;
    bus.nrzi_sending = 1'b0;
    bus.ph_req       = 1'b0;
    bus.ph_in_bit    = 1'b0;
    bus.ph_sending   = 1'b0;
    bus.sent         = 1'b0;
    nextCycle();
    nextCycle();
    checkGrants("rst", 1'b0, 1'b0);
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_timeout_err", 32'(bus.timeout_err), 32'(0));
    checkOutput("rst_enc_sending", 32'(bus.enc_sending), 32'(0));
    reset_n = 1'b1;
    nextCycle();
  endtask

  // Scoreboard consumer: every valid encoder cycle must match the next queued bit.
  always @(negedge clock) begin
    logic expBit;
    #2;
    if (bus.enc_sending === 1'b1) begin
      checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'(1));
      if (sbQ.size() > 0) begin
        expBit = sbQ.pop_front();
        checkOutput("sb_enc_bit", 32'(bus.enc_in_bit), 32'(expBit));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grantCycles;
    int errPulses;
    checks = 0;
    errors = 0;

    // Single NRZI packet: 1-cycle grant latency, 8 bits, sent, 2-cycle gap.
    doReset();
    bus.nrzi_req = 1'b1;
    #1;
    checkGrants("s1_pre", 1'b0, 1'b0);
    nextCycle();
    checkGrants("s1_latency", 1'b1, 1'b0);
    checkOutput("s1_busy", 32'(bus.busy), 32'(1));
    applyStimulus(1'b1, 8'hA5, 8, 1'b0);
    bus.nrzi_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkGrants("s1_wait", 1'b1, 1'b0);
    end
    bus.sent = 1'b1;
    nextCycle();
    bus.sent = 1'b0;
    checkGrants("s1_after_sent", 1'b0, 1'b0);
    checkOutput("s1_gap1_busy", 32'(bus.busy), 32'(1));
    checkOutput("s1_no_err", 32'(bus.timeout_err), 32'(0));
    nextCycle();
    checkOutput("s1_gap2_busy", 32'(bus.busy), 32'(1));
    nextCycle();
    checkOutput("s1_idle_busy", 32'(bus.busy), 32'(0));
    bus.sent = 1'b1;
    nextCycle();
    bus.sent = 1'b0;
    checkOutput("s1_stray_sent_busy", 32'(bus.busy), 32'(0));

    // Simultaneous requests out of reset: NRZI first, then PH, then NRZI again.
    doReset();
    bus.nrzi_req = 1'b1;
    bus.ph_req   = 1'b1;
    nextCycle();
    checkGrants("s2_tie1", 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h3C, 4, 1'b0);
    nextCycle();
    bus.sent = 1'b1;
    nextCycle();
    bus.sent = 1'b0;
    checkGrants("s2_gap1", 1'b0, 1'b0);
    nextCycle();
    checkGrants("s2_gap2", 1'b0, 1'b0);
    nextCycle();
    checkGrants("s2_idle", 1'b0, 1'b0);
    checkOutput("s2_idle_busy", 32'(bus.busy), 32'(0));
    nextCycle();
    checkGrants("s2_tie2", 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h96, 4, 1'b0);
    nextCycle();
    bus.sent = 1'b1;
    nextCycle();
    bus.sent = 1'b0;
    waitGrant("s2_tie3", 1'b1, 10);
    bus.nrzi_req = 1'b0;
    bus.ph_req   = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("s2_cancel_busy", 32'(bus.busy), 32'(0));

    // NRZI packet with PH noise, then PH timeout, then a tie PH must still win.
    doReset();
    bus.nrzi_req = 1'b1;
    nextCycle();
    checkGrants("s3_nrzi", 1'b1, 1'b0);
    bus.ph_sending = 1'b1;
    bus.ph_in_bit  = 1'b1;
    #1;
    checkOutput("s3_noise_sending", 32'(bus.enc_sending), 32'(0));
    checkOutput("s3_noise_bit", 32'(bus.enc_in_bit), 32'(0));
    nextCycle();
    applyStimulus(1'b1, 8'h5A, 6, 1'b1);
    bus.nrzi_req = 1'b0;
    nextCycle();
    bus.sent = 1'b1;
    nextCycle();
    bus.sent = 1'b0;
    bus.ph_req = 1'b1;
    waitGrant("s3_ph", 1'b0, 10);
    grantCycles = 1;
    errPulses   = 0;
    for (int i = 0; i < 1100; i++) begin
      nextCycle();
      if (bus.timeout_err === 1'b1) errPulses++;
      if (bus.ph_grant === 1'b1) grantCycles++;
      else break;
    end
    checkOutput("s3_timeout_cycles", 32'(grantCycles), 32'(1000));
    checkOutput("s3_err_with_drop", 32'(bus.timeout_err), 32'(1));
    bus.nrzi_req = 1'b1;
    nextCycle();
    if (bus.timeout_err === 1'b1) errPulses++;
    checkOutput("s3_err_pulses", 32'(errPulses), 32'(1));
    checkOutput("s3_gap_busy", 32'(bus.busy), 32'(1));
    waitGrant("s3_tie_after_abort", 1'b0, 5);
    bus.nrzi_req = 1'b0;
    bus.ph_req   = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("s3_cancel_busy", 32'(bus.busy), 32'(0));

    // One-cycle PH request with no data: grant then straight back to IDLE.
    bus.ph_req = 1'b1;
    nextCycle();
    bus.ph_req = 1'b0;
    checkGrants("s5_grant", 1'b0, 1'b1);
    nextCycle();
    checkGrants("s5_dropped", 1'b0, 1'b0);
    checkOutput("s5_no_gap_busy", 32'(bus.busy), 32'(0));

    // Reset asserted while waiting for sent clears everything at once.
    bus.nrzi_req = 1'b1;
    nextCycle();
    checkGrants("s6_grant", 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h01, 1, 1'b0);
    bus.nrzi_req = 1'b0;
    nextCycle();
    checkGrants("s6_wait_sent", 1'b1, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkGrants("s6_async", 1'b0, 1'b0);
    checkOutput("s6_async_busy", 32'(bus.busy), 32'(0));
    checkOutput("s6_async_enc_sending", 32'(bus.enc_sending), 32'(0));
    checkOutput("s6_async_enc_bit", 32'(bus.enc_in_bit), 32'(0));
    checkOutput("s6_async_err", 32'(bus.timeout_err), 32'(0));
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    checkOutput("s6_idle_busy", 32'(bus.busy), 32'(0));
    checkOutput("s6_idle_err", 32'(bus.timeout_err), 32'(0));

    nextCycle();
    checkOutput("sb_empty", 32'(sbQ.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
